// File: rtl/edge_event_arbiter_if.sv
// Event handshake bundle between edge_event_arbiter (master) and its consumer (slave).
interface edge_event_arbiter_if #(
  parameter int unsigned CH_W = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_rise;

  modport master (output evt_valid, output evt_ch, output evt_rise, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, input evt_rise, output evt_ready);
endinterface

// File: rtl/edge_event_arbiter.sv
// Per-channel edge detector with pending/overflow tracking and a round-robin event offer FSM.
// Define EDGE_SYNC2_EN to put a synchronizer ahead of the sampling flops (+1 cycle latency).
module edge_event_arbiter #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CH_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     din,
  edge_event_arbiter_if.master evt,
  output logic [N_CH-1:0]     ovf,
  input  logic                ovf_clr
);

  typedef enum logic {IDLE, OFFER} state_e;

  state_e          state_q;
  logic [N_CH-1:0] s_in;
  logic [N_CH-1:0] s_q, s_dly_q;
  logic [N_CH-1:0] edge_w;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] pol_q, pol_d;
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic [CH_W-1:0] rr_q, rr_nxt;
  logic [CH_W-1:0] ch_q;
  logic            rise_q;
  logic            valid_q;
  logic            hs;
  logic            sel_found;
  logic [CH_W-1:0] sel_ch;

`ifdef EDGE_SYNC2_EN
  // First synchronizer stage; s_q serves as the second stage.
  logic [N_CH-1:0] meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) meta_q <= '0;
    else     meta_q <= din;
  end

  assign s_in = meta_q;
`else
  assign s_in = din;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= '0;
      s_dly_q <= '0;
    end else begin
      s_q     <= s_in;
      s_dly_q <= s_q;
    end
  end

  assign edge_w = s_q ^ s_dly_q;
  assign hs     = valid_q & evt.evt_ready;

  // A fresh edge on the channel being consumed re-arms it rather than overflowing.
  always_comb begin
    logic consume;
    consume = 1'b0;
    pend_d  = pend_q;
    pol_d   = pol_q;
    ovf_d   = ovf_clr ? '0 : ovf_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      consume = hs && (ch_q == CH_W'(i));
      if (edge_w[i]) begin
        if (pend_q[i] && !consume) begin
          ovf_d[i] = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
          pol_d[i]  = s_q[i];
        end
      end else if (consume) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      pol_q  <= '0;
      ovf_q  <= '0;
    end else begin
      pend_q <= pend_d;
      pol_q  <= pol_d;
      ovf_q  <= ovf_d;
    end
  end

  // First pending channel at or after rr_q, wrapping modulo N_CH.
  always_comb begin
    int unsigned     idx;
    logic [CH_W-1:0] idx_c;
    idx       = 0;
    idx_c     = '0;
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      idx_c = CH_W'(idx);
      if (!sel_found && pend_q[idx_c]) begin
        sel_found = 1'b1;
        sel_ch    = idx_c;
      end
    end
  end

  assign rr_nxt = (ch_q == CH_W'(N_CH - 1)) ? '0 : CH_W'(ch_q + 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      ch_q    <= '0;
      rise_q  <= 1'b0;
      rr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            ch_q    <= sel_ch;
            rise_q  <= pol_q[sel_ch];
            valid_q <= 1'b1;
            state_q <= OFFER;
          end
        end
        OFFER: begin
          if (evt.evt_ready) begin
            valid_q <= 1'b0;
            rr_q    <= rr_nxt;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_ch    = ch_q;
  assign evt.evt_rise  = rise_q;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: latency, glitch rejection, round-robin, overflow, reset.
module tb_edge_event_arbiter;

`ifdef EDGE_SYNC2_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic [3:0] ovf;
  logic       ovf_clr;
  int         n_pass;
  int         n_total;

  edge_event_arbiter_if #(.CH_W(2)) bus ();

  edge_event_arbiter #(.N_CH(4), .CH_W(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .evt     (bus),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_evt(input string tag, input logic [1:0] ch, input logic rise);
    chk({tag, "_valid"}, 32'(bus.evt_valid), 32'd1);
    chk({tag, "_ch"},    32'(bus.evt_ch),    32'(ch));
    chk({tag, "_rise"},  32'(bus.evt_rise),  32'(rise));
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst           = 1'b1;
    din           = '0;
    ovf_clr       = 1'b0;
    bus.evt_ready = 1'b0;
    steps(2);
    chk("rst_valid", 32'(bus.evt_valid), 32'd0);
    chk("rst_ch",    32'(bus.evt_ch),    32'd0);
    chk("rst_rise",  32'(bus.evt_rise),  32'd0);
    chk("rst_ovf",   32'(ovf),           32'd0);
    rst = 1'b0;

    // Rising edge on ch0: valid for exactly one cycle after LAT cycles
    bus.evt_ready = 1'b1;
    din[0] = 1'b1;
    for (int c = 1; c <= LAT + 2; c++) begin
      step();
      chk("lat_valid", 32'(bus.evt_valid), (c == LAT + 1) ? 32'd1 : 32'd0);
      if (c == LAT + 1) begin
        chk("lat_ch",   32'(bus.evt_ch),   32'd0);
        chk("lat_rise", 32'(bus.evt_rise), 32'd1);
      end
    end

    // Falling edge on ch0, then a short glitch between clock edges
    din[0] = 1'b0;
    steps(LAT + 1);
    chk_evt("fall0", 2'd0, 1'b0);
    step();
    chk("fall0_done", 32'(bus.evt_valid), 32'd0);
    #5 din[0] = 1'b1;
    #3 din[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("glitch_valid", 32'(bus.evt_valid), 32'd0);
    end
    chk("glitch_ovf", 32'(ovf), 32'd0);

    // Simultaneous rises on ch1/ch3, lone ch2, then simultaneous falls on ch1/ch3
    din[1] = 1'b1;
    din[3] = 1'b1;
    steps(LAT + 1);
    chk_evt("pair_a", 2'd1, 1'b1);
    step();
    chk("pair_gap", 32'(bus.evt_valid), 32'd0);
    step();
    chk_evt("pair_b", 2'd3, 1'b1);
    step();
    chk("pair_done", 32'(bus.evt_valid), 32'd0);
    din[2] = 1'b1;
    steps(LAT + 1);
    chk_evt("solo2", 2'd2, 1'b1);
    step();
    din[1] = 1'b0;
    din[3] = 1'b0;
    steps(LAT + 1);
    chk_evt("rr_a", 2'd3, 1'b0);
    steps(2);
    chk_evt("rr_b", 2'd1, 1'b0);
    step();
    chk("rr_done", 32'(bus.evt_valid), 32'd0);

    // Overflow on ch2 while stalled; clear coinciding with the set loses
    din[2] = 1'b0;
    steps(LAT + 1);
    chk_evt("fall2", 2'd2, 1'b0);
    step();
    bus.evt_ready = 1'b0;
    din[2] = 1'b1;
    step();
    din[2] = 1'b0;
    steps(LAT - 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(ovf), 32'h4);
    chk_evt("ovf_offer", 2'd2, 1'b1);
    steps(3);
    chk_evt("ovf_hold", 2'd2, 1'b1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf), 32'd0);
    bus.evt_ready = 1'b1;
    step();
    chk("ovf_take", 32'(bus.evt_valid), 32'd0);
    steps(3);
    chk("ovf_nodup", 32'(bus.evt_valid), 32'd0);

    // Reset during OFFER, with din[1] still high at release
    bus.evt_ready = 1'b0;
    din[1] = 1'b1;
    steps(LAT + 1);
    chk_evt("pre_rst", 2'd1, 1'b1);
    #5 rst = 1'b1;
    #1 chk("async_valid", 32'(bus.evt_valid), 32'd0);
    chk("async_ch", 32'(bus.evt_ch), 32'd0);
    step();
    chk("rst_hold_valid", 32'(bus.evt_valid), 32'd0);
    rst = 1'b0;
    bus.evt_ready = 1'b1;
    steps(LAT + 1);
    chk_evt("post_rst", 2'd1, 1'b1);
    step();
    chk("post_rst_done", 32'(bus.evt_valid), 32'd0);
    din[1] = 1'b0;
    steps(LAT + 1);
    chk_evt("fall1", 2'd1, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("quiet_after_rst", 32'(bus.evt_valid), 32'd0);
    end

    // Handshake on ch0 in the same cycle as a new falling edge on ch0
    bus.evt_ready = 1'b0;
    din[0] = 1'b1;
    steps(LAT + 1);
    chk_evt("hs_first", 2'd0, 1'b1);
    din[0] = 1'b0;
    steps(LAT - 1);
    chk_evt("hs_stall", 2'd0, 1'b1);
    bus.evt_ready = 1'b1;
    step();
    chk("hs_gap", 32'(bus.evt_valid), 32'd0);
    step();
    chk_evt("hs_second", 2'd0, 1'b0);
    chk("hs_ovf", 32'(ovf), 32'd0);
    step();
    chk("hs_done", 32'(bus.evt_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
